control_sequencer: RTL and testbench

- Hardwired control unit directly upstream of the datapath.
- A 3-bit sequence counter plus instruction decoder turns the fetched instruction word into per-cycle bus-select, register load/clear/increment, memory, and ALU strobes. These strobes drive the datapath's matching inputs.
- Implements fetch, decode, indirect addressing, the seven memory-reference instructions, and a register-reference subset, including halt.

---
 rtl/cpu_ctrl_pkg.sv | 51 +++++
 rtl/seq_counter.sv | 29 ++
 rtl/control_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired control sequencer: bus selects, ALU ops,
// opcodes, strobe bit positions and sequence-count names.
package cpu_ctrl_pkg;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_TR   = 3'd6;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  localparam logic [3:0] ALU_AND     = 4'd0;
  localparam logic [3:0] ALU_ADD     = 4'd1;
  localparam logic [3:0] ALU_PASS_DR = 4'd2;
  localparam logic [3:0] ALU_CMA     = 4'd3;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  // ld vector positions {TR,IR,AC,DR,PC,AR}
  localparam int unsigned LD_AR = 0;
  localparam int unsigned LD_PC = 1;
  localparam int unsigned LD_DR = 2;
  localparam int unsigned LD_AC = 3;
  localparam int unsigned LD_IR = 4;
  localparam int unsigned LD_TR = 5;

  // clr/inr vector positions {TR,AC,DR,PC,AR}
  localparam int unsigned REG_AR = 0;
  localparam int unsigned REG_PC = 1;
  localparam int unsigned REG_DR = 2;
  localparam int unsigned REG_AC = 3;
  localparam int unsigned REG_TR = 4;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;
  localparam logic [2:0] T6 = 3'd6;

endpackage

// File: rtl/seq_counter.sv
// Sequence counter: synchronous clear beats hold, hold beats increment.
module seq_counter #(
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             hold_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (!hold_i && inc_i) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: sequence count plus instruction decode produce the
// per-cycle bus select, register and memory strobes for the datapath.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned wsize = 16,
  parameter int unsigned addr  = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [wsize-1:0] ir,
  input  logic             dr_zero,
  input  logic             ac_zero,
  input  logic             ac_msb,
  output logic [2:0]       s,
  output logic [5:0]       ld,
  output logic [4:0]       clr,
  output logic [4:0]       inr,
  output logic             memread,
  output logic             memwrite,
  output logic [3:0]       aluop,
  output logic             I,
  output logic [2:0]       sc,
  output logic             halted
);

  logic [2:0]      sc_q;
  logic            sc_clr, sc_inc, sc_hold;
  logic            i_d, i_q;
  logic            halted_d, halted_q;
  logic [2:0]      opcode;
  logic            is_reg;
  logic [addr-1:0] rr;
  logic            unused_rr;

  assign opcode    = ir[wsize-2 -: 3];
  assign is_reg    = (opcode == OP_REG);
  assign rr        = ir[addr-1:0];
  assign unused_rr = ^{rr[10], rr[8:6], rr[1]};

  seq_counter #(
    .Width (3)
  ) u_seq_counter (
    .clk_i   (CLK),
    .clr_i   (sc_clr),
    .inc_i   (sc_inc),
    .hold_i  (sc_hold),
    .count_o (sc_q)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      i_q      <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      i_q      <= i_d;
      halted_q <= halted_d;
    end
  end

  // Next-state: where the count goes and when I / halted change.
  always_comb begin
    sc_clr   = 1'b0;
    sc_inc   = 1'b0;
    sc_hold  = 1'b0;
    i_d      = i_q;
    halted_d = halted_q;
    if (RST) begin
      sc_clr = 1'b1;
    end else if (halted_q) begin
      sc_hold = 1'b1;
    end else begin
      unique case (sc_q)
        T0, T1: sc_inc = 1'b1;
        T2: begin
          sc_inc = 1'b1;
          i_d    = ir[wsize-1];
        end
        T3: begin
          if (is_reg) begin
            sc_clr = 1'b1;
            if (!i_q && rr[0]) halted_d = 1'b1;
          end else begin
            sc_inc = 1'b1;
          end
        end
        T4: begin
          if (opcode inside {OP_AND, OP_ADD, OP_LDA, OP_BSA, OP_ISZ}) sc_inc = 1'b1;
          else sc_clr = 1'b1;
        end
        T5: begin
          if (opcode == OP_ISZ) sc_inc = 1'b1;
          else sc_clr = 1'b1;
        end
        default: sc_clr = 1'b1;
      endcase
    end
  end

  always_comb begin
    s        = BUS_NONE;
    ld       = '0;
    clr      = '0;
    inr      = '0;
    memread  = 1'b0;
    memwrite = 1'b0;
    aluop    = ALU_PASS_DR;
    if (!RST && !halted_q) begin
      unique case (sc_q)
        T0: begin
          s         = BUS_PC;
          ld[LD_AR] = 1'b1;
        end
        T1: begin
          s           = BUS_MEM;
          memread     = 1'b1;
          ld[LD_IR]   = 1'b1;
          inr[REG_PC] = 1'b1;
        end
        T2: begin
          s         = BUS_IR;
          ld[LD_AR] = 1'b1;
        end
        T3: begin
          if (!is_reg) begin
            if (i_q) begin
              s         = BUS_MEM;
              memread   = 1'b1;
              ld[LD_AR] = 1'b1;
            end
          end else if (!i_q) begin
            // CLA wins over CMA; skips collapse onto a single PC increment.
            if (rr[11]) begin
              clr[REG_AC] = 1'b1;
            end else if (rr[9]) begin
              ld[LD_AC] = 1'b1;
              aluop     = ALU_CMA;
            end
            if (rr[5]) inr[REG_AC] = 1'b1;
            if ((rr[4] && !ac_msb) || (rr[3] && ac_msb) || (rr[2] && ac_zero)) begin
              inr[REG_PC] = 1'b1;
            end
          end
        end
        T4: begin
          case (opcode)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              s         = BUS_MEM;
              memread   = 1'b1;
              ld[LD_DR] = 1'b1;
            end
            OP_STA: begin
              s        = BUS_AC;
              memwrite = 1'b1;
            end
            OP_BUN: begin
              s         = BUS_AR;
              ld[LD_PC] = 1'b1;
            end
            OP_BSA: begin
              s           = BUS_PC;
              memwrite    = 1'b1;
              inr[REG_AR] = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_AND: begin
              ld[LD_AC] = 1'b1;
              aluop     = ALU_AND;
            end
            OP_ADD: begin
              ld[LD_AC] = 1'b1;
              aluop     = ALU_ADD;
            end
            OP_LDA: ld[LD_AC] = 1'b1;
            OP_BSA: begin
              s         = BUS_AR;
              ld[LD_PC] = 1'b1;
            end
            OP_ISZ: inr[REG_DR] = 1'b1;
            default: ;
          endcase
        end
        T6: begin
          if (opcode == OP_ISZ) begin
            s           = BUS_DR;
            memwrite    = 1'b1;
            inr[REG_PC] = dr_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign I      = i_q;
  assign sc     = sc_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: per-instruction expected strobe sequences built from the
// instruction rules, compared cycle by cycle against the sequencer.
module tb_control_sequencer;
  import cpu_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] ir = '0;
  logic        dr_zero = 1'b0, ac_zero = 1'b0, ac_msb = 1'b0;
  logic [2:0]  s;
  logic [5:0]  ld;
  logic [4:0]  clr, inr;
  logic        memread, memwrite;
  logic [3:0]  aluop;
  logic        i_flag;
  logic [2:0]  sc;
  logic        halted;

  always #5 CLK = ~CLK;

  control_sequencer #(
    .wsize (16),
    .addr  (12)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ir       (ir),
    .dr_zero  (dr_zero),
    .ac_zero  (ac_zero),
    .ac_msb   (ac_msb),
    .s        (s),
    .ld       (ld),
    .clr      (clr),
    .inr      (inr),
    .memread  (memread),
    .memwrite (memwrite),
    .aluop    (aluop),
    .I        (i_flag),
    .sc       (sc),
    .halted   (halted)
  );

  typedef struct packed {
    logic [2:0] s;
    logic [5:0] ld;
    logic [4:0] clr;
    logic [4:0] inr;
    logic       mr;
    logic       mw;
    logic [3:0] alu;
    logic [2:0] sc;
    logic       i;
    logic       halted;
  } cyc_t;

  cyc_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   model_i = 1'b0;
  bit   model_halted = 1'b0;

  function automatic cyc_t blank(input int t, input bit i, input bit h);
    cyc_t c;
    c = '0;
    c.alu = ALU_PASS_DR;
    c.sc = 3'(t);
    c.i = i;
    c.halted = h;
    return c;
  endfunction

  function automatic cyc_t actual();
    cyc_t c;
    c.s = s; c.ld = ld; c.clr = clr; c.inr = inr; c.mr = memread; c.mw = memwrite;
    c.alu = aluop; c.sc = sc; c.i = i_flag; c.halted = halted;
    return c;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input cyc_t exp);
    cyc_t act;
    act = actual();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (sc got %0d exp %0d)", name, act, exp, act.sc,
               exp.sc);
    end
  endtask

  // Expected cycle list for one instruction, from fetch through last execute step.
  task automatic build(input logic [15:0] w, input bit az, input bit am, input bit dz);
    cyc_t c;
    bit ni;
    int op;
    exp_q.delete();
    c = blank(0, model_i, 0); c.s = BUS_PC; c.ld[LD_AR] = 1'b1; exp_q.push_back(c);
    c = blank(1, model_i, 0); c.s = BUS_MEM; c.mr = 1'b1; c.ld[LD_IR] = 1'b1;
    c.inr[REG_PC] = 1'b1; exp_q.push_back(c);
    c = blank(2, model_i, 0); c.s = BUS_IR; c.ld[LD_AR] = 1'b1; exp_q.push_back(c);
    ni = w[15];
    op = int'(w[14:12]);
    c = blank(3, ni, 0);
    if (op == 7) begin
      if (!ni) begin
        if (w[11]) c.clr[REG_AC] = 1'b1;
        else if (w[9]) begin c.ld[LD_AC] = 1'b1; c.alu = ALU_CMA; end
        if (w[5]) c.inr[REG_AC] = 1'b1;
        if ((w[4] && !am) || (w[3] && am) || (w[2] && az)) c.inr[REG_PC] = 1'b1;
        model_halted = w[0];
      end
      exp_q.push_back(c);
    end else begin
      if (ni) begin c.s = BUS_MEM; c.mr = 1'b1; c.ld[LD_AR] = 1'b1; end
      exp_q.push_back(c);
      c = blank(4, ni, 0);
      case (op)
        0, 1, 2, 6: begin c.s = BUS_MEM; c.mr = 1'b1; c.ld[LD_DR] = 1'b1; end
        3: begin c.s = BUS_AC; c.mw = 1'b1; end
        4: begin c.s = BUS_AR; c.ld[LD_PC] = 1'b1; end
        default: begin c.s = BUS_PC; c.mw = 1'b1; c.inr[REG_AR] = 1'b1; end
      endcase
      exp_q.push_back(c);
      if (op != 3 && op != 4) begin
        c = blank(5, ni, 0);
        case (op)
          0: begin c.ld[LD_AC] = 1'b1; c.alu = ALU_AND; end
          1: begin c.ld[LD_AC] = 1'b1; c.alu = ALU_ADD; end
          2: c.ld[LD_AC] = 1'b1;
          5: begin c.s = BUS_AR; c.ld[LD_PC] = 1'b1; end
          default: c.inr[REG_DR] = 1'b1;
        endcase
        exp_q.push_back(c);
      end
      if (op == 6) begin
        c = blank(6, ni, 0); c.s = BUS_DR; c.mw = 1'b1; c.inr[REG_PC] = dz;
        exp_q.push_back(c);
      end
    end
    model_i = ni;
  endtask

  task automatic run_cycles(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      #1;
      check($sformatf("%s T%0d", name, k), exp_q[k]);
      tick();
    end
  endtask

  task automatic run_instr(input string name, input logic [15:0] w, input bit az,
                           input bit am, input bit dz);
    ir = w; ac_zero = az; ac_msb = am; dr_zero = dz;
    build(w, az, am, dz);
    run_cycles(name, exp_q.size());
  endtask

  task automatic test_reset();
    RST = 1'b1;
    ir = 16'($urandom);
    tick();
    for (int k = 0; k < 2; k++) begin
      #1;
      check($sformatf("reset hold %0d", k), blank(0, 0, 0));
      tick();
    end
    RST = 1'b0;
    model_i = 1'b0;
    model_halted = 1'b0;
  endtask

  task automatic test_lda();
    run_instr("lda", 16'h2005, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (sc !== 3'd0 || i_flag !== 1'b0) begin
      errors++;
      $display("FAIL lda_return: sc=%0d I=%0b expected sc=0 I=0", sc, i_flag);
    end
  endtask

  task automatic test_add_indirect();
    run_instr("add_ind", 16'h9010, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_isz();
    run_instr("isz_dz1", 16'h6020, 1'b0, 1'b0, 1'b1);
    run_instr("isz_dz0", 16'h6020, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_cla_sza();
    run_instr("cla_sza", 16'h7804, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (sc !== 3'd0) begin
      errors++;
      $display("FAIL cla_sza_return: sc=%0d expected 0", sc);
    end
  endtask

  task automatic test_hlt();
    run_instr("hlt", 16'h7001, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      ac_zero = 1'($urandom); ac_msb = 1'($urandom); dr_zero = 1'($urandom);
      #1;
      check($sformatf("halted %0d", k), blank(0, model_i, 1));
      tick();
    end
    RST = 1'b1;
    #1;
    check("halt reset", blank(0, model_i, 1));
    tick();
    RST = 1'b0;
    model_i = 1'b0;
    model_halted = 1'b0;
    run_instr("after_hlt", 16'h3044, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_bsa();
    ir = 16'h5030; ac_zero = 1'b0; ac_msb = 1'b0; dr_zero = 1'b0;
    build(16'h5030, 1'b0, 1'b0, 1'b0);
    run_cycles("bsa_pre", 5);
    RST = 1'b1;
    #1;
    check("bsa reset T5", blank(5, 0, 0));
    tick();
    RST = 1'b0;
    model_i = 1'b0;
    run_instr("after_bsa_rst", 16'h4123, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int n = 0; n < 40; n++) begin
      w = 16'($urandom);
      if (w[14:12] == 3'd7 && !w[15]) w[0] = 1'b0;
      run_instr($sformatf("rand%0d_%h", n, w), w, 1'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_lda();
    test_add_indirect();
    test_isz();
    test_cla_sza();
    test_hlt();
    test_reset_mid_bsa();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
